// File: rtl/trap_pkg.sv
// Shared types and trap code constants for the NOOP trap detector and its monitor.
package trap_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        TRAPPED = 1'b1
    } trap_state_e;

    localparam logic [31:0] GOOD_TRAP  = 32'h0000_0000;
    localparam logic [31:0] BAD_TRAP   = 32'h0000_0001;
    localparam logic [31:0] STALL_TRAP = 32'h0000_0003;
    // Value the monitor shows while no trap has been latched.
    localparam logic [31:0] NO_TRAP    = 32'hFFFF_FFFF;

endpackage

// File: rtl/commit_trap_select.sv
// Combinational slot filter: finds the first trapping commit slot and the slots that count.
module commit_trap_select #(
    parameter int COMMIT_WIDTH = 2,
    parameter int IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1,
    parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0] valid_i,
    input  logic [COMMIT_WIDTH-1:0] trap_i,
    output logic [COMMIT_WIDTH-1:0] eff_mask_o,
    output logic [CNT_W-1:0]        popcnt_o,
    output logic                    trap_found_o,
    output logic [IDX_W-1:0]        trap_idx_o,
    output logic [IDX_W-1:0]        last_idx_o
);

    logic blocked;

    // Walk oldest to youngest; everything after the first valid trap is dropped.
    always_comb begin
        blocked      = 1'b0;
        eff_mask_o   = '0;
        popcnt_o     = '0;
        trap_found_o = 1'b0;
        trap_idx_o   = '0;
        last_idx_o   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (valid_i[i] && !blocked) begin
                eff_mask_o[i] = 1'b1;
                popcnt_o      = popcnt_o + CNT_W'(1);
                last_idx_o    = IDX_W'(i);
                if (trap_i[i]) begin
                    trap_found_o = 1'b1;
                    trap_idx_o   = IDX_W'(i);
                    blocked      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/noop_trap_detector.sv
// Commit-stage watcher: counts cycles/instructions and latches the first NOOP or stall trap.
module noop_trap_detector
    import trap_pkg::*;
#(
    parameter int          COMMIT_WIDTH = 2,
    parameter int          STALL_LIMIT  = 5000,
    parameter logic [31:0] STALL_CODE   = STALL_TRAP
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid,
    input  logic [COMMIT_WIDTH-1:0]    commit_is_trap,
    input  logic [64*COMMIT_WIDTH-1:0] commit_pc,
    input  logic [32*COMMIT_WIDTH-1:0] commit_a0,
    output logic                       isNoopTrap,
    output logic [31:0]                trapCode,
    output logic [63:0]                trapPC,
    output logic [31:0]                cycleCnt,
    output logic [31:0]                instrCnt
);

    localparam int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int SW    = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT);
    localparam logic [SW-1:0] STALL_TRIG = SW'(STALL_LIMIT - 1);

    trap_state_e state_q, state_d;

    logic [COMMIT_WIDTH-1:0] eff_mask;
    logic [CNT_W-1:0]        popcnt;
    logic                    trap_found;
    logic [IDX_W-1:0]        trap_idx;
    logic [IDX_W-1:0]        last_idx;
    logic                    any_valid;
    logic                    stall_hit;

    logic        trap_q,  trap_d;
    logic [31:0] code_q,  code_d;
    logic [63:0] pc_q,    pc_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] last_pc_q, last_pc_d;
    logic [SW-1:0] stall_q, stall_d;

    commit_trap_select #(
        .COMMIT_WIDTH(COMMIT_WIDTH),
        .IDX_W       (IDX_W),
        .CNT_W       (CNT_W)
    ) u_select (
        .valid_i     (commit_valid),
        .trap_i      (commit_is_trap),
        .eff_mask_o  (eff_mask),
        .popcnt_o    (popcnt),
        .trap_found_o(trap_found),
        .trap_idx_o  (trap_idx),
        .last_idx_o  (last_idx)
    );

    // The oldest valid slot is always effective, so this equals "any slot valid".
    assign any_valid = |eff_mask;
    assign stall_hit = !any_valid && (stall_q == STALL_TRIG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            trap_q    <= 1'b0;
            code_q    <= '0;
            pc_q      <= '0;
            cycle_q   <= '0;
            instr_q   <= '0;
            last_pc_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            last_pc_q <= last_pc_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && (trap_found || stall_hit)) begin
            state_d = TRAPPED;
        end
    end

    // In TRAPPED every register simply holds its value.
    always_comb begin
        trap_d    = trap_q;
        code_d    = code_q;
        pc_d      = pc_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        last_pc_d = last_pc_q;
        stall_d   = stall_q;
        if (state_q == RUN) begin
            cycle_d = cycle_q + 32'd1;
            instr_d = instr_q + {{(32 - CNT_W){1'b0}}, popcnt};
            if (any_valid) begin
                last_pc_d = commit_pc[64*int'(last_idx) +: 64];
                stall_d   = '0;
            end else if (stall_q != STALL_MAX) begin
                stall_d   = stall_q + SW'(1);
            end
            if (trap_found) begin
                trap_d = 1'b1;
                code_d = commit_a0[32*int'(trap_idx) +: 32];
                pc_d   = commit_pc[64*int'(trap_idx) +: 64];
            end else if (stall_hit) begin
                trap_d = 1'b1;
                code_d = STALL_CODE;
                pc_d   = last_pc_q;
            end
        end
    end

    assign isNoopTrap = trap_q;
    assign trapCode   = code_q;
    assign trapPC     = pc_q;
    assign cycleCnt   = cycle_q;
    assign instrCnt   = instr_q;

endmodule
